// File: rtl/sgen_nco_pkg.sv
// Shared types and helpers for the NCO: quadrant enum, ROM entry generator, quadrant decode.
// The cosine path is compiled in only when SGEN_NCO_COS_EN is defined (see sgen_nco_core).
package sgen_nco_pkg;

  typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quad_t;

  typedef struct packed {
    logic negate;
    logic mirror;
  } quad_map_t;

  // Second half of the period is negated; odd quadrants walk the quarter-wave backwards.
  function automatic quad_map_t quad_decode(quad_t q);
    quad_map_t m;
    m.negate = (q == Q2) || (q == Q3);
    m.mirror = (q == Q1) || (q == Q3);
    return m;
  endfunction

  // Sampling at k+0.5 makes entry k and entry 2^d-1-k mirror images, so the symmetry is exact.
  function automatic int rom_entry(int w, int d, int k);
    real pi;
    real x;
    pi = 3.14159265358979323846;
    x  = ((2.0 ** w) - 1.0) * $sin(pi / 2.0 * (real'(k) + 0.5) / (2.0 ** d));
    return $rtoi(x + 0.5);
  endfunction

endpackage

// File: rtl/sgen_nco_rom.sv
// Quarter-wave sine ROM with quadrant symmetry and a registered signed output sample.
// Reset clears the sample; enable low holds it.
module sgen_nco_rom
  import sgen_nco_pkg::*;
#(
  parameter int gp_rom_width = 8,
  parameter int gp_rom_depth = 6
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ena,
  input  quad_t                          quad,
  input  logic [gp_rom_depth-1:0]        idx,
  output logic signed [gp_rom_width:0]   sample
);

  logic [gp_rom_width-1:0] rom_table [2**gp_rom_depth];

  for (genvar gi = 0; gi < 2**gp_rom_depth; gi++) begin : g_rom
    assign rom_table[gi] = gp_rom_width'(rom_entry(gp_rom_width, gp_rom_depth, gi));
  end

  quad_map_t               map;
  logic [gp_rom_depth-1:0] rd_idx;
  logic [gp_rom_width:0]   mag_ext;

  // Mirrored index 2^D-1-i is just the bitwise complement of i.
  always_comb begin
    map     = quad_decode(quad);
    rd_idx  = map.mirror ? ~idx : idx;
    mag_ext = {1'b0, rom_table[rd_idx]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sample <= '0;
    end else if (ena) begin
      sample <= map.negate ? -mag_ext : mag_ext;
    end
  end

endmodule

// File: rtl/sgen_nco_core.sv
// NCO core: phase accumulator driving quarter-wave ROM lookups for sine and (optional) cosine.
// Define SGEN_NCO_COS_EN to build the cosine path; otherwise o_cos is held at zero.
module sgen_nco_core
  import sgen_nco_pkg::*;
#(
  parameter int gp_rom_width        = 8,
  parameter int gp_rom_depth        = 6,
  parameter int gp_phase_accu_width = 16
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic                                i_ena,
  input  logic [gp_phase_accu_width-1:0]      i_fcw,
  output logic signed [gp_rom_width:0]        o_sin,
  output logic signed [gp_rom_width:0]        o_cos
);

  localparam int P = gp_phase_accu_width;
  localparam int D = gp_rom_depth;

  logic [P-1:0] acc_reg;
  quad_t        quad;
  logic [D-1:0] idx;

  // Outputs look up the pre-update phase, so the first enabled edge after reset yields phase 0.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc_reg <= '0;
    end else if (i_ena) begin
      acc_reg <= acc_reg + i_fcw;
    end
  end

  assign quad = quad_t'(acc_reg[P-1:P-2]);
  assign idx  = acc_reg[P-3:P-2-D];

  // Phase bits below the ROM index are deliberately truncated.
  if (P > D + 2) begin : g_trunc
    logic unused_trunc;
    assign unused_trunc = ^acc_reg[P-3-D:0];
  end

  sgen_nco_rom #(
    .gp_rom_width (gp_rom_width),
    .gp_rom_depth (gp_rom_depth)
  ) u_sin_rom (
    .clk    (i_clk),
    .rst    (i_rst),
    .ena    (i_ena),
    .quad   (quad),
    .idx    (idx),
    .sample (o_sin)
  );

`ifdef SGEN_NCO_COS_EN
  quad_t cos_quad;

  // Cosine leads sine by a quarter turn.
  assign cos_quad = quad_t'(quad + 2'd1);

  sgen_nco_rom #(
    .gp_rom_width (gp_rom_width),
    .gp_rom_depth (gp_rom_depth)
  ) u_cos_rom (
    .clk    (i_clk),
    .rst    (i_rst),
    .ena    (i_ena),
    .quad   (cos_quad),
    .idx    (idx),
    .sample (o_cos)
  );
`else
  assign o_cos = '0;
`endif

endmodule

// File: tb/tb_sgen_nco_core.sv
// Self-checking bench for sgen_nco_core: directed scenarios plus randomized traffic vs an angle-based model.
module tb_sgen_nco_core;

  localparam int W = 8;
  localparam int D = 6;
  localparam int P = 16;
`ifdef SGEN_NCO_COS_EN
  localparam bit COS_EN = 1'b1;
`else
  localparam bit COS_EN = 1'b0;
`endif

  logic                i_clk;
  logic                i_rst;
  logic                i_ena;
  logic [P-1:0]        i_fcw;
  logic signed [W:0]   o_sin;
  logic signed [W:0]   o_cos;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  // Model state.
  longint m_acc = 0;
  int     m_sin = 0;
  int     m_cos = 0;

  sgen_nco_core #(
    .gp_rom_width        (W),
    .gp_rom_depth        (D),
    .gp_phase_accu_width (P)
  ) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_ena (i_ena),
    .i_fcw (i_fcw),
    .o_sin (o_sin),
    .o_cos (o_cos)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Ideal wave sampled at the centre of the addressed phase bin, rounded half away from zero.
  function automatic int wave(longint acc, bit cosine);
    real    th;
    real    v;
    longint n;
    n  = acc >> (P - 2 - D);
    th = 2.0 * 3.14159265358979323846 * (real'(n) + 0.5) / real'(4 * (2 ** D));
    v  = ((2.0 ** W) - 1.0) * (cosine ? $cos(th) : $sin(th));
    if (v >= 0.0) return $rtoi(v + 0.5);
    return -$rtoi(-v + 0.5);
  endfunction

  function automatic int cexp(int v);
    return COS_EN ? v : 0;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model advances on the same edge the DUT does.
  always @(posedge i_clk) begin
    if (i_rst) begin
      m_acc = 0;
      m_sin = 0;
      m_cos = 0;
    end else if (i_ena) begin
      m_sin = wave(m_acc, 1'b0);
      m_cos = cexp(wave(m_acc, 1'b1));
      m_acc = (m_acc + longint'(i_fcw)) % (64'd1 << P);
    end
  end

  always @(negedge i_clk) begin
    if (chk_on) begin
      chk("model_sin", int'(o_sin), m_sin);
      chk("model_cos", int'(o_cos), m_cos);
      $display("cyc t=%0t rst=%0b ena=%0b fcw=%04h sin=%0d cos=%0d", $time, i_rst, i_ena, i_fcw,
               o_sin, o_cos);
    end
  end

  task automatic tick();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic lit(string name, int es, int ec);
    chk({name, "_sin"}, int'(o_sin), es);
    chk({name, "_cos"}, int'(o_cos), cexp(ec));
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
  endtask

  initial begin
    int qs[4];
    int qc[4];
    int hs;
    int hc;
    qs = '{3, 255, -3, -255};
    qc = '{255, -3, -255, 3};

    i_rst = 1'b1;
    i_ena = 1'b1;
    i_fcw = 16'h1234;

    // Pin the model itself with hand-computed points.
    chk("pin_ph0_sin", wave(0, 1'b0), 3);
    chk("pin_ph0_cos", wave(0, 1'b1), 255);
    chk("pin_q1_sin", wave(64'h4000, 1'b0), 255);
    chk("pin_q3_sin", wave(64'hC000, 1'b0), -255);
    chk("pin_last_sin", wave(64'hFFFF, 1'b0), -3);

    // Reset held with enable high.
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_on = 1'b1;
      lit("reset", 0, 0);
    end

    // Phase 0 with zero frequency.
    i_rst = 1'b0;
    i_fcw = 16'h0000;
    for (int k = 0; k < 4; k++) begin
      tick();
      lit("phase0", 3, 255);
    end

    // Quarter turns.
    do_reset();
    i_fcw = 16'h4000;
    for (int k = 0; k < 8; k++) begin
      tick();
      lit("quarter", qs[k % 4], qc[k % 4]);
    end

    // Enable hold.
    do_reset();
    i_fcw = 16'h0100;
    for (int k = 0; k < 20; k++) tick();
    hs = int'(o_sin);
    hc = int'(o_cos);
    i_ena = 1'b0;
    i_fcw = 16'h7777;
    for (int k = 0; k < 5; k++) begin
      tick();
      lit("hold", hs, hc);
    end
    i_ena = 1'b1;
    i_fcw = 16'h0100;
    for (int k = 0; k < 10; k++) tick();

    // Negative frequency / wrap.
    do_reset();
    i_fcw = 16'hFFFF;
    tick();
    lit("wrap0", 3, 255);
    tick();
    lit("wrap1", -3, 255);
    for (int k = 0; k < 300; k++) tick();

    // Mid-run reset.
    do_reset();
    i_fcw = 16'h0400;
    for (int k = 0; k < 10; k++) tick();
    i_rst = 1'b1;
    tick();
    lit("midrst", 0, 0);
    i_rst = 1'b0;
    tick();
    lit("restart", 3, 255);

    // Randomized traffic.
    for (int k = 0; k < 2000; k++) begin
      i_fcw = P'($urandom);
      i_ena = ($urandom_range(0, 9) < 8);
      i_rst = ($urandom_range(0, 99) < 2);
      tick();
    end

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish before %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
